// File: rtl/conways_wr_pkg.sv
// Shared types and constants for the Conway board-update write sequencer.
package conways_wr_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_RESP     = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_MISMATCH = 2'b11
   } err_code_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam int         NUM_REGS   = 4;
   localparam int         REG_STRIDE = 4;

   // Word idx of the packed board image; word 0 sits in the low bits.
   function automatic logic [31:0] board_word(input logic [NUM_REGS*32-1:0] board,
                                              input logic [1:0]             idx);
      return board[{idx, 5'd0} +: 32];
   endfunction

endpackage

// File: rtl/conways_wr_timeout.sv
// Loadable down-counter guarding each handshake wait; expired is high once
// the count has run out, restart reloads it on entry to a new wait state.
module conways_wr_timeout #(
   parameter int WIDTH = 11
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             restart,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // NOTE: flops are written only with non-blocking (<=) so every reader sees the pre-edge value.
   always_ff @(posedge ACLK) begin
      if (ARESET)
         count <= '0;
      else if (restart)
         count <= load_value;
      else if (count != '0)
         count <= count - WIDTH'(1);
   end

   assign expired = (count == '0);

endmodule

// File: rtl/conways_wr_seq.sv
// AXI4-Lite master writing a 4-word board image to consecutive registers.
// Optional read-back verification of every word: define CONWAYS_WR_READBACK_EN.
module conways_wr_seq
   import conways_wr_pkg::*;
#(
   parameter int          C_M_AXI_ADDR_WIDTH = 32,
   parameter int          C_M_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES     = 1024
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic                            start,
   input  logic [NUM_REGS*32-1:0]          board_data,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [1:0]                      err_code,
   output logic [1:0]                      err_index,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   state_t                          state, state_nxt;
   err_code_t                       err_q, err_new;
   logic [1:0]                      word_idx, err_idx_q;
   logic [NUM_REGS*32-1:0]          board_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
   logic                            awvalid_q, wvalid_q, error_q;
   logic                            accept, next_word, set_err, last_word;
   logic                            aw_hs, w_hs, aw_fin, w_fin;
   logic                            tmo_restart, tmo_expired;
`ifdef CONWAYS_WR_READBACK_EN
   logic                            arvalid_q, ar_hs, issue_ar;
`endif

   assign accept    = (state == IDLE) && start;
   assign last_word = (word_idx == 2'(NUM_REGS - 1));
   assign aw_hs     = awvalid_q && M_AXI_AWREADY;
   assign w_hs      = wvalid_q && M_AXI_WREADY;
   // A channel is finished once its valid has dropped or it handshakes now.
   assign aw_fin    = !awvalid_q || M_AXI_AWREADY;
   assign w_fin     = !wvalid_q || M_AXI_WREADY;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      set_err   = 1'b0;
      err_new   = ERR_NONE;
      next_word = 1'b0;
`ifdef CONWAYS_WR_READBACK_EN
      issue_ar  = 1'b0;
`endif
      case (state)
         IDLE:    if (start) state_nxt = WR_ADDR;
         WR_ADDR: begin
            if (aw_fin && w_fin) begin
               state_nxt = WR_RESP;
            end else if (tmo_expired) begin
               state_nxt = DONE;
               set_err   = 1'b1;
               err_new   = ERR_TIMEOUT;
            end
         end
         WR_RESP: begin
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != RESP_OKAY) begin
                  state_nxt = DONE;
                  set_err   = 1'b1;
                  err_new   = ERR_RESP;
               end else begin
`ifdef CONWAYS_WR_READBACK_EN
                  state_nxt = RD_ADDR;
                  issue_ar  = 1'b1;
`else
                  state_nxt = last_word ? DONE : WR_ADDR;
                  next_word = !last_word;
`endif
               end
            end else if (tmo_expired) begin
               state_nxt = DONE;
               set_err   = 1'b1;
               err_new   = ERR_TIMEOUT;
            end
         end
`ifdef CONWAYS_WR_READBACK_EN
         RD_ADDR: begin
            if (M_AXI_ARREADY) begin
               state_nxt = RD_DATA;
            end else if (tmo_expired) begin
               state_nxt = DONE;
               set_err   = 1'b1;
               err_new   = ERR_TIMEOUT;
            end
         end
         RD_DATA: begin
            if (M_AXI_RVALID) begin
               if (M_AXI_RRESP != RESP_OKAY || M_AXI_RDATA != wdata_q) begin
                  state_nxt = DONE;
                  set_err   = 1'b1;
                  err_new   = (M_AXI_RRESP != RESP_OKAY) ? ERR_RESP : ERR_MISMATCH;
               end else begin
                  state_nxt = last_word ? DONE : WR_ADDR;
                  next_word = !last_word;
               end
            end else if (tmo_expired) begin
               state_nxt = DONE;
               set_err   = 1'b1;
               err_new   = ERR_TIMEOUT;
            end
         end
`endif
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign tmo_restart = (state_nxt != state);

   conways_wr_timeout #(.WIDTH(TMO_W)) u_timeout (
      .ACLK       (ACLK),
      .ARESET     (ARESET),
      .restart    (tmo_restart),
      .load_value (TMO_W'(TIMEOUT_CYCLES - 1)),
      .expired    (tmo_expired)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= IDLE;
         word_idx  <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         error_q   <= 1'b0;
         err_q     <= ERR_NONE;
         err_idx_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            word_idx  <= '0;
            awaddr_q  <= C_M_AXI_ADDR_WIDTH'(BASE_ADDR);
            wdata_q   <= board_word(board_data, 2'd0);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            error_q   <= 1'b0;
            err_q     <= ERR_NONE;
            err_idx_q <= '0;
         end else if (next_word) begin
            word_idx  <= word_idx + 2'd1;
            awaddr_q  <= awaddr_q + C_M_AXI_ADDR_WIDTH'(REG_STRIDE);
            wdata_q   <= board_word(board_q, word_idx + 2'd1);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
         end else begin
            if (aw_hs || state_nxt == DONE) awvalid_q <= 1'b0;
            if (w_hs || state_nxt == DONE)  wvalid_q  <= 1'b0;
         end
         if (set_err) begin
            error_q   <= 1'b1;
            err_q     <= err_new;
            err_idx_q <= word_idx;
         end
      end
   end

   // NOTE: board_q is pure data qualified by the FSM, so it carries no reset.
   always_ff @(posedge ACLK) begin
      if (accept) board_q <= board_data;
   end

`ifdef CONWAYS_WR_READBACK_EN
   assign ar_hs = arvalid_q && M_AXI_ARREADY;

   always_ff @(posedge ACLK) begin
      if (ARESET)
         arvalid_q <= 1'b0;
      else if (issue_ar)
         arvalid_q <= 1'b1;
      else if (ar_hs || state_nxt == DONE)
         arvalid_q <= 1'b0;
   end

   assign M_AXI_ARADDR  = awaddr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = (state == RD_DATA);
`else
   logic rd_unused;
   assign rd_unused     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
   assign M_AXI_ARADDR  = '0;
   assign M_AXI_ARVALID = 1'b0;
   assign M_AXI_RREADY  = 1'b0;
`endif

   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = (state == WR_RESP);
   assign M_AXI_ARPROT  = 3'b000;

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign error     = error_q;
   assign err_code  = err_q;
   assign err_index = err_idx_q;

endmodule

// File: tb/tb_conways_wr_seq.sv
// Directed bench for conways_wr_seq with a small reactive AXI4-Lite slave.
// Build with +define+CONWAYS_WR_READBACK_EN to exercise the read-back path.
module tb_conways_wr_seq;

   localparam logic [31:0]  BASE = 32'h4000_0100;
   localparam int           TMO  = 16;
   localparam logic [127:0] D1   = 128'hbeef0011_dead0011_abcd0001_0101FFFF;
   localparam logic [127:0] D2   = 128'h11112222_33334444_55556666_77778888;
`ifdef CONWAYS_WR_READBACK_EN
   localparam int           LAT  = 17;  // four cycles per word plus DONE
`else
   localparam int           LAT  = 9;   // cycle 1 is the one after the start edge
`endif

   logic         tb_ACLK = 1'b0;
   logic         ARESET, start;
   logic [127:0] board_data;
   logic         busy, done, error;
   logic [1:0]   err_code, err_index;
   logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]   M_AXI_WSTRB;
   logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;
   logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic         M_AXI_RVALID, M_AXI_RREADY;

   int n_cmp = 0;
   int n_err = 0;

   always #5 tb_ACLK = ~tb_ACLK;

   conways_wr_seq #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .BASE_ADDR          (BASE),
      .TIMEOUT_CYCLES     (TMO)
   ) dut (
      .ACLK          (tb_ACLK),
      .ARESET        (ARESET),
      .start         (start),
      .board_data    (board_data),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .err_code      (err_code),
      .err_index     (err_index),
      .M_AXI_AWADDR  (M_AXI_AWADDR),
      .M_AXI_AWPROT  (M_AXI_AWPROT),
      .M_AXI_AWVALID (M_AXI_AWVALID),
      .M_AXI_AWREADY (M_AXI_AWREADY),
      .M_AXI_WDATA   (M_AXI_WDATA),
      .M_AXI_WSTRB   (M_AXI_WSTRB),
      .M_AXI_WVALID  (M_AXI_WVALID),
      .M_AXI_WREADY  (M_AXI_WREADY),
      .M_AXI_BRESP   (M_AXI_BRESP),
      .M_AXI_BVALID  (M_AXI_BVALID),
      .M_AXI_BREADY  (M_AXI_BREADY),
      .M_AXI_ARADDR  (M_AXI_ARADDR),
      .M_AXI_ARPROT  (M_AXI_ARPROT),
      .M_AXI_ARVALID (M_AXI_ARVALID),
      .M_AXI_ARREADY (M_AXI_ARREADY),
      .M_AXI_RDATA   (M_AXI_RDATA),
      .M_AXI_RRESP   (M_AXI_RRESP),
      .M_AXI_RVALID  (M_AXI_RVALID),
      .M_AXI_RREADY  (M_AXI_RREADY)
   );

   // Slave configuration knobs and observation log.
   int          aw_delay_cfg = 0;
   int          bad_b_idx    = -1;
   bit          b_never      = 1'b0;
   bit          rd_zero_first = 1'b0;
   logic        log_clr      = 1'b0;

   int          aw_wait, aw_run, w_run, n_wr, n_rd;
   int          aw_run_log [0:15];
   int          w_run_log  [0:15];
   logic [31:0] log_addr   [0:15];
   logic [31:0] log_data   [0:15];
   logic [31:0] pend_addr, pend_data, last_wdata, aw_prev;
   logic        aw_got, w_got, aw_hold, aw_unstable, ar_seen;
   logic        aw_hs, w_hs, have_aw, have_w;
   logic [31:0] addr_v, data_v;

   assign M_AXI_AWREADY = (aw_wait >= aw_delay_cfg);
   assign M_AXI_WREADY  = 1'b1;
   assign M_AXI_ARREADY = 1'b1;
   assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
   assign have_aw = aw_got || aw_hs;
   assign have_w  = w_got || w_hs;
   assign addr_v  = aw_got ? pend_addr : M_AXI_AWADDR;
   assign data_v  = w_got ? pend_data : M_AXI_WDATA;

   always @(posedge tb_ACLK) begin
      if (ARESET || log_clr) begin
         aw_wait <= 0; aw_run <= 0; w_run <= 0; n_wr <= 0; n_rd <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; aw_hold <= 1'b0; aw_unstable <= 1'b0;
         ar_seen <= 1'b0; M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
         M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'b00;
         last_wdata <= '0; aw_prev <= '0; pend_addr <= '0; pend_data <= '0;
      end else begin
         aw_hold <= M_AXI_AWVALID && !M_AXI_AWREADY;
         aw_prev <= M_AXI_AWADDR;
         if (aw_hold && M_AXI_AWADDR != aw_prev) aw_unstable <= 1'b1;
         if (aw_hs) begin
            aw_got <= 1'b1; pend_addr <= M_AXI_AWADDR; aw_wait <= 0;
            aw_run_log[n_wr] <= aw_run + 1; aw_run <= 0;
         end else if (M_AXI_AWVALID) begin
            aw_wait <= aw_wait + 1; aw_run <= aw_run + 1;
         end
         if (w_hs) begin
            w_got <= 1'b1; pend_data <= M_AXI_WDATA;
            w_run_log[n_wr] <= w_run + 1; w_run <= 0;
         end else if (M_AXI_WVALID) begin
            w_run <= w_run + 1;
         end
         if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
         if (have_aw && have_w) begin
            log_addr[n_wr] <= addr_v; log_data[n_wr] <= data_v;
            last_wdata <= data_v; n_wr <= n_wr + 1;
            aw_got <= 1'b0; w_got <= 1'b0;
            if (!b_never) begin
               M_AXI_BVALID <= 1'b1;
               M_AXI_BRESP  <= (n_wr == bad_b_idx) ? 2'b10 : 2'b00;
            end
         end
         if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_RVALID <= 1'b1;
            M_AXI_RDATA  <= (rd_zero_first && n_rd == 0) ? 32'h0 : last_wdata;
            n_rd <= n_rd + 1;
         end
         if (M_AXI_ARVALID || M_AXI_RREADY) ar_seen <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      @(negedge tb_ACLK);
      log_clr = 1'b1;
      @(posedge tb_ACLK);
      #1 log_clr = 1'b0;
   endtask

   // Start is sampled at the posedge this task waits for.
   task automatic pulse_start(input logic [127:0] d);
      @(negedge tb_ACLK);
      start      = 1'b1;
      board_data = d;
      @(posedge tb_ACLK);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge tb_ACLK);
         if (done) begin
            cyc = i;
            break;
         end
      end
      check("done_seen", done, 1'b1);
   endtask

   task automatic check_idle_outputs(input string pfx);
      check({pfx, "_busy"},    busy, 1'b0);
      check({pfx, "_done"},    done, 1'b0);
      check({pfx, "_error"},   error, 1'b0);
      check({pfx, "_errcode"}, err_code, 2'b00);
      check({pfx, "_erridx"},  err_index, 2'b00);
      check({pfx, "_valids"},  {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 3'b000);
      check({pfx, "_readys"},  {M_AXI_BREADY, M_AXI_RREADY}, 2'b00);
      check({pfx, "_addr"},    {M_AXI_AWADDR, M_AXI_ARADDR}, 64'h0);
      check({pfx, "_wdata"},   M_AXI_WDATA, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      logic [31:0] w1 [0:3];
      logic [31:0] w2 [0:3];
      w1[0] = 32'h0101FFFF; w1[1] = 32'habcd0001; w1[2] = 32'hdead0011; w1[3] = 32'hbeef0011;
      w2[0] = 32'h77778888; w2[1] = 32'h55556666; w2[2] = 32'h33334444; w2[3] = 32'h11112222;
      ARESET     = 1'b1;
      start      = 1'b0;
      board_data = '0;

      // Reset state
      repeat (3) @(posedge tb_ACLK);
      @(negedge tb_ACLK);
      check_idle_outputs("rst");
      check("rst_static", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, {3'b000, 3'b000, 4'hF});
      ARESET = 1'b0;

      // Always-ready slave, nominal board update
      clear_log();
      pulse_start(D1);
      check("t1_busy", busy, 1'b1);
      check("t1_first_valids", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
      wait_done(cyc);
      check("t1_latency", cyc, LAT);
      check("t1_error", {error, err_code}, 3'b000);
      @(negedge tb_ACLK);
      check("t1_done_one_cycle", {done, busy}, 2'b00);
      check("t1_nwr", n_wr, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_addr%0d", i), log_addr[i], BASE + 32'(4 * i));
         check($sformatf("t1_data%0d", i), log_data[i], w1[i]);
      end
`ifdef CONWAYS_WR_READBACK_EN
      check("t1_reads", n_rd, 4);
`else
      check("t1_ar_quiet", ar_seen, 1'b0);
`endif

      // AWREADY held off: AWVALID three cycles, WVALID one; start while busy ignored
      aw_delay_cfg = 2;
      clear_log();
      pulse_start(D2);
      repeat (2) @(negedge tb_ACLK);
      pulse_start(D1);
      wait_done(cyc);
      check("t2_error", {error, err_code}, 3'b000);
      check("t2_nwr", n_wr, 4);
      check("t2_aw_run0", aw_run_log[0], 3);
      check("t2_w_run0", w_run_log[0], 1);
      check("t2_aw_run3", aw_run_log[3], 3);
      check("t2_aw_stable", aw_unstable, 1'b0);
      for (int i = 0; i < 4; i++)
         check($sformatf("t2_data%0d", i), log_data[i], w2[i]);
      check("t2_addr3", log_addr[3], BASE + 32'hC);
      aw_delay_cfg = 0;

      // SLVERR on word 2
      bad_b_idx = 2;
      clear_log();
      pulse_start(D1);
      wait_done(cyc);
      check("t3_err", {error, err_code, err_index}, {1'b1, 2'b01, 2'd2});
      check("t3_nwr", n_wr, 3);
      @(negedge tb_ACLK);
      check("t3_idle", {busy, M_AXI_AWVALID, M_AXI_WVALID}, 3'b000);
      check("t3_error_sticky", error, 1'b1);
      bad_b_idx = -1;

      // B never returned: timeout exactly TMO cycles after WR_RESP entry
      b_never = 1'b1;
      clear_log();
      pulse_start(D1);
      for (int i = 0; i < 20; i++) begin
         @(negedge tb_ACLK);
         if (M_AXI_BREADY) break;
      end
      check("t4_wr_resp_entry", M_AXI_BREADY, 1'b1);
      for (int i = 1; i <= TMO; i++) begin
         @(negedge tb_ACLK);
         if (i == TMO - 1) check("t4_no_err_early", {error, done}, 2'b00);
         if (i == TMO) begin
            check("t4_timeout", {error, err_code, err_index, done}, {1'b1, 2'b10, 2'd0, 1'b1});
            check("t4_dropped", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b000);
         end
      end
      b_never = 1'b0;
      clear_log();
      pulse_start(D2);
      check("t4_err_cleared", {busy, error, err_code}, {1'b1, 1'b0, 2'b00});
      wait_done(cyc);
      check("t4_second_ok", {error, err_code}, 3'b000);
      check("t4_second_nwr", n_wr, 4);

      // Reset during word 1 WR_RESP
      clear_log();
      pulse_start(D1);
      for (int i = 0; i < 20; i++) begin
         @(negedge tb_ACLK);
         if (n_wr == 2 && M_AXI_BREADY) break;
      end
      check("t5_word1_wait", {n_wr == 2, M_AXI_BREADY}, 2'b11);
      ARESET = 1'b1;
      @(negedge tb_ACLK);
      check_idle_outputs("t5_rst");
      ARESET = 1'b0;
      pulse_start(D2);
      wait_done(cyc);
      check("t5_latency", cyc, LAT);
      check("t5_nwr", n_wr, 4);
      check("t5_addr0", log_addr[0], BASE);
      check("t5_data0", log_data[0], w2[0]);

`ifdef CONWAYS_WR_READBACK_EN
      // Read-back returns zero for word 0
      rd_zero_first = 1'b1;
      clear_log();
      pulse_start(D1);
      wait_done(cyc);
      check("t6_mismatch", {error, err_code, err_index}, {1'b1, 2'b11, 2'd0});
      check("t6_nwr", n_wr, 1);
      rd_zero_first = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conways_wr_seq.md
CONWAYS_WR_SEQ -- requirements
Module: conways_wr_seq

Interface
REQ-001 Param C_M_AXI_ADDR_WIDTH, 32, AXI4-Lite master address width.
REQ-002 Param C_M_AXI_DATA_WIDTH, 32, AXI4-Lite master data width; only 32 supported.
REQ-003 Param BASE_ADDR, 32'h0000_0000, address of board register 0.
REQ-004 Param TIMEOUT_CYCLES, 1024, maximum wait for any single handshake.
REQ-005 ACLK  in  1  sole clock; all logic on rising edge.
REQ-006 ARESET  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request to write one 4-word board update.
REQ-008 board_data  in  128  word i = bits [32i+31:32i], i=0..3.
REQ-009 busy  out  1  sequence in progress.
REQ-010 done  out  1  one-cycle pulse at sequence end (success or error).
REQ-011 error  out  1  sticky failure flag, cleared by next accepted start.
REQ-012 err_code  out  2  00 none, 01 SLVERR/DECERR, 10 timeout, 11 readback mismatch.
REQ-013 err_index  out  2  word index that failed.
REQ-014 M_AXI_AW*/W*/B* master ports: AWADDR, AWPROT, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY.
REQ-015 M_AXI_AR*/R* master ports: ARADDR, ARPROT, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY.

Function
REQ-016 FSM states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-017 start is accepted only in IDLE; board_data is latched on acceptance; start in any other state is ignored.
REQ-018 Words are written in order 0..3, word i at BASE_ADDR + 4*i.
REQ-019 WR_ADDR: AWVALID and WVALID assert together; each deasserts independently after its own handshake; the FSM moves to WR_RESP once both have completed.
REQ-020 AWADDR/WDATA remain stable while valid is high; WSTRB = 4'hF; AWPROT = ARPROT = 3'b000.
REQ-021 BREADY is high only in WR_RESP; BRESP != 2'b00 -> err_code 01, err_index = i, go to DONE.
REQ-022 A timeout counter restarts on entry to each wait state; reaching TIMEOUT_CYCLES -> err_code 10, go to DONE with all valids dropped.
REQ-023 After word 3 completes successfully, go to DONE; in DONE, done = 1 for one cycle, then go to IDLE.
REQ-024 busy = 1 in every state except IDLE.
REQ-025 Latency with always-ready slave, BVALID one cycle after the W handshake, macro off: start sampled at edge 0 -> done high in cycle 9.

Reset
REQ-026 While ARESET is high at an edge: FSM -> IDLE; busy, done, error, all VALID and READY outputs = 0; err_code, err_index, address and data outputs = 0.
REQ-027 Reset mid-sequence abandons the sequence without completing it; no done pulse is produced.

Configuration
REQ-028 Macro CONWAYS_WR_READBACK_EN: after each OKAY B response, the block issues an AR to the same address (RD_ADDR), then waits in RD_DATA with RREADY high.
REQ-029 RDATA differing from the written word, or RRESP != OKAY, sets err_code 11 or 01 respectively and sets err_index.
REQ-030 Without the macro, RD_ADDR and RD_DATA are unreachable, ARVALID = RREADY = 0, and the AR/R inputs are ignored.

Structure
REQ-031 Package conways_wr_pkg holds: FSM state enum, err_code typedef, RESP_OKAY = 2'b00, NUM_REGS = 4, REG_STRIDE = 4.
REQ-032 Sub-module conways_wr_timeout: loadable down-counter with restart/expire ports, instantiated once.

Verification
REQ-033 Always-ready slave, start with board_data 128'hbeef0011_dead0011_abcd0001_0101FFFF -> writes to BASE+0..0xC in order, carrying 0101FFFF, abcd0001, dead0011, beef0011; done in cycle 9; error = 0.
REQ-034 Slave delays AWREADY 3 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID held 3 cycles with a stable address; sequence completes OKAY.
REQ-035 Slave returns BRESP = 2'b10 on word 2 -> error = 1, err_code 01, err_index 2; word 3 is never issued; done pulses.
REQ-036 BVALID is never returned, with TIMEOUT_CYCLES = 16 -> err_code 10 exactly 16 cycles after WR_RESP entry; second start accepted afterwards clears error.
REQ-037 ARESET asserted during word 1 WR_RESP -> next cycle all outputs at reset values; new start runs from word 0.
REQ-038 With CONWAYS_WR_READBACK_EN, slave returns RDATA = 32'h0 for word 0 -> err_code 11, err_index 0.
